axi_cmd_reg_map_writer: RTL and testbench
=========================================

// Module: axi_cmd_reg_map_writer
// PURPOSE
//  Downstream stage of the RX command generator. Consumes its 32-bit AXI-Stream payload (tdata/tvalid/tlast).
//  Each frame is a list of (address, data) word pairs. The block stages writes in shadow registers.
//  At tlast it commits the whole frame to the live register map in one cycle, and only if the frame is clean.
//  The live map is a flat vector consumed by the radar timing/DDS control logic.
// PARAMETERS
//  REG_WIDTH  4   bytes per register (1..4); data word bits [8*REG_WIDTH-1:0] are used, upper bits ignored
//  NUM_REG    6   number of registers in the map
//  ADDR_BITS  8   address field width, taken from addr word bits [ADDR_BITS-1:0]
// PORTS
//  axi_tclk        in   1                       clock
//  axi_treset      in   1                       synchronous reset, active-high
//  enable          in   1                       allow acceptance of new frames
//  s_axis_tdata    in   32                      command payload word
//  s_axis_tvalid   in   1                       payload valid
//  s_axis_tlast    in   1                       last word of frame
//  s_axis_tready   out  1                       payload ready
//  reg_map_data    out  NUM_REG*8*REG_WIDTH     live registers; reg i at [i*8*REG_WIDTH +: 8*REG_WIDTH]
//  reg_update      out  NUM_REG                 1-cycle pulse per register changed by a commit
//  frame_done      out  1                       1-cycle pulse: frame committed
//  frame_err       out  1                       1-cycle pulse: frame discarded
//  err_count       out  16                      discarded-frame count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values: all outputs 0, s_axis_tready 0, shadow registers and dirty mask cleared, state ADDR.
//  Beat = s_axis_tvalid & s_axis_tready.
//  in_frame: set on a beat without tlast, cleared on a beat with tlast.
//  s_axis_tready (combinational) = in_frame ? 1 : (enable & state==ADDR).
//   Dropping enable mid-frame does not stall the frame. Only the next frame start is blocked.
//  FSM:
//   ADDR: on a beat, latch idx = tdata[ADDR_BITS-1:0] and set bad_addr = (idx >= NUM_REG).
//         If tlast is set on this beat, the frame has an odd word count: discard, stay in ADDR. Else go to DATA.
//   DATA: on a beat, if !bad_addr, write shadow[idx] and set dirty[idx]. A later write to the same idx wins.
//         If tlast is set, end the frame and go to ADDR. Otherwise go to ADDR for the next pair.
//  frame_bad: sticky. Set by bad_addr or by the odd-count case. Cleared at frame end.
//  Frame end, clean (tlast on a DATA beat, frame_bad=0 and current pair valid):
//   - In the next cycle, reg_map_data[i] takes the shadow value for every dirty i, including the final pair.
//     The final pair is merged combinationally at commit.
//   - reg_update = dirty mask (final pair included); frame_done = 1. Both are 1-cycle pulses.
//  Frame end, bad:
//   - Live map unchanged, reg_update = 0, frame_err pulses in the next cycle, err_count += 1 (saturating).
//  Any frame end clears the dirty mask and frame_bad. Shadow contents may persist; only dirty entries are ever committed.
//  Latency: beat with tlast in cycle N -> map update and pulses in cycle N+1. The next frame can be accepted in cycle N+1.
//  A frame with zero dirty registers that ends clean (all pairs valid) is not possible; every clean frame has at least one pair.
//  Reset mid-frame: shadow/dirty/in_frame cleared, live map returns to 0, no pulses.
// STRUCTURE
//  Shared package (cmd_pkg): FSM state encodings (ST_ADDR, ST_DATA) and the WRITE_CMD/command word constants shared with the RX command generator.
//  One sub-module: cmd_reg_bank holds the shadow array, dirty mask, commit merge and the live map.
//   It takes wr_en/wr_idx/wr_data/commit/abort and outputs reg_map_data/reg_update.
//  The top level holds the FSM, the ready logic, the error flags and err_count.
// TESTING
//  1. Clean frame: pairs (0,0x11),(5,0x55) with tlast on 0x55 -> next cycle reg0=0x11, reg5=0x55,
//     reg_update=6'b100001, frame_done=1.
//  2. Bad address: pairs (2,0xAA),(9,0xBB) with NUM_REG=6 -> map unchanged, frame_err=1, err_count=1, reg_update=0.
//  3. Odd frame: single word 0x3 with tlast -> frame_err=1. A following clean frame (1,0x7) commits reg1=0x7.
//  4. Backpressure/enable: enable=0 -> s_axis_tready=0 while idle. Drop enable after the first beat -> frame still completes and commits.
//  5. Same address twice: (3,0x1),(3,0x2) -> reg3=0x2, reg_update=6'b001000. Back-to-back frames with no idle cycle both commit.
//  6. Reset asserted after an addr beat mid-frame -> all outputs 0. The next full frame commits normally.
//     err_count preset to 0xFFFF plus one more bad frame -> stays 0xFFFF.

Source files
------------

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared command-path constants and FSM encodings
package cmd_pkg;

  localparam int CMD_WORD_W = 32;
  localparam logic [7:0] WRITE_CMD = 8'h57;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } wr_state_e;

endpackage

// File: rtl/cmd_reg_bank.sv
// rtl/cmd_reg_bank.sv - shadow registers, dirty mask and atomic commit into the live map
module cmd_reg_bank #(
  parameter int REG_WIDTH = 4,
  parameter int NUM_REG   = 6,
  parameter int ADDR_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_BITS-1:0]           wr_idx,
  input  logic [8*REG_WIDTH-1:0]         wr_data,
  input  logic                           commit,
  input  logic                           abort,
  output logic [NUM_REG*8*REG_WIDTH-1:0] reg_map_data,
  output logic [NUM_REG-1:0]             reg_update
);

  localparam int DW = 8 * REG_WIDTH;

  logic [DW-1:0]         shadow_q [NUM_REG];
  logic [DW-1:0]         shadow_d [NUM_REG];
  logic [NUM_REG-1:0]    dirty_q, dirty_d;
  logic [NUM_REG-1:0]    upd_q, upd_d;
  logic [NUM_REG-1:0]    hit;
  logic [NUM_REG*DW-1:0] map_q, map_d;

  // The final pair of a frame arrives in the commit cycle, so it is merged here before the copy.
  always_comb begin
    shadow_d = shadow_q;
    map_d    = map_q;
    upd_d    = '0;
    hit      = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      hit[i] = wr_en && (wr_idx == ADDR_BITS'(i));
      if (hit[i]) shadow_d[i] = wr_data;
    end
    dirty_d = dirty_q | hit;
    if (commit) begin
      for (int i = 0; i < NUM_REG; i++) begin
        if (dirty_d[i]) map_d[i*DW +: DW] = shadow_d[i];
      end
      upd_d   = dirty_d;
      dirty_d = '0;
    end else if (abort) begin
      dirty_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REG; i++) shadow_q[i] <= '0;
      dirty_q <= '0;
      upd_q   <= '0;
      map_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      upd_q    <= upd_d;
      map_q    <= map_d;
    end
  end

  assign reg_map_data = map_q;
  assign reg_update   = upd_q;

endmodule

// File: rtl/axi_cmd_reg_map_writer.sv
// rtl/axi_cmd_reg_map_writer.sv - address/data pair parser that commits clean frames to the register map
module axi_cmd_reg_map_writer
  import cmd_pkg::*;
#(
  parameter int REG_WIDTH = 4,
  parameter int NUM_REG   = 6,
  parameter int ADDR_BITS = 8
) (
  input  logic                           axi_tclk,
  input  logic                           axi_treset,
  input  logic                           enable,
  input  logic [CMD_WORD_W-1:0]          s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [NUM_REG*8*REG_WIDTH-1:0] reg_map_data,
  output logic [NUM_REG-1:0]             reg_update,
  output logic                           frame_done,
  output logic                           frame_err,
  output logic [15:0]                    err_count
);

  wr_state_e            state_q, state_d;
  logic                 in_frame_q, in_frame_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 bad_addr_q, bad_addr_d;
  logic                 frame_bad_q, frame_bad_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_err_q, frame_err_d;
  logic [15:0]          err_count_q, err_count_d;

  logic                 beat;
  logic                 addr_oob;
  logic                 wr_en, commit, abort;
  logic                 unused_bits;

  assign unused_bits = ^s_axis_tdata;

  // Once a frame has started it always runs to completion, regardless of enable.
  assign s_axis_tready = in_frame_q | (enable & (state_q == ST_ADDR));
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign addr_oob      = {{(32-ADDR_BITS){1'b0}}, s_axis_tdata[ADDR_BITS-1:0]} >= 32'(NUM_REG);

  always_comb begin
    state_d      = state_q;
    in_frame_d   = in_frame_q;
    idx_d        = idx_q;
    bad_addr_d   = bad_addr_q;
    frame_bad_d  = frame_bad_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    wr_en        = 1'b0;
    commit       = 1'b0;
    abort        = 1'b0;
    if (beat) begin
      in_frame_d = ~s_axis_tlast;
      case (state_q)
        ST_ADDR: begin
          idx_d      = s_axis_tdata[ADDR_BITS-1:0];
          bad_addr_d = addr_oob;
          if (s_axis_tlast) begin
            abort       = 1'b1;
            frame_err_d = 1'b1;
            frame_bad_d = 1'b0;
          end else begin
            frame_bad_d = frame_bad_q | addr_oob;
            state_d     = ST_DATA;
          end
        end
        ST_DATA: begin
          wr_en   = ~bad_addr_q;
          state_d = ST_ADDR;
          if (s_axis_tlast) begin
            commit       = ~frame_bad_q;
            abort        = frame_bad_q;
            frame_done_d = ~frame_bad_q;
            frame_err_d  = frame_bad_q;
            frame_bad_d  = 1'b0;
          end
        end
        default: state_d = ST_ADDR;
      endcase
    end
    err_count_d = err_count_q;
    if (frame_err_d && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      state_q      <= ST_ADDR;
      in_frame_q   <= 1'b0;
      idx_q        <= '0;
      bad_addr_q   <= 1'b0;
      frame_bad_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_frame_q   <= in_frame_d;
      idx_q        <= idx_d;
      bad_addr_q   <= bad_addr_d;
      frame_bad_q  <= frame_bad_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  cmd_reg_bank #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_REG   (NUM_REG),
    .ADDR_BITS (ADDR_BITS)
  ) u_bank (
    .clk          (axi_tclk),
    .rst          (axi_treset),
    .wr_en        (wr_en),
    .wr_idx       (idx_q),
    .wr_data      (s_axis_tdata[8*REG_WIDTH-1:0]),
    .commit       (commit),
    .abort        (abort),
    .reg_map_data (reg_map_data),
    .reg_update   (reg_update)
  );

  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_axi_cmd_reg_map_writer.sv
// tb/tb_axi_cmd_reg_map_writer.sv - frame-level model plus directed checks for the register map writer
module tb_axi_cmd_reg_map_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [31:0]  tdata = '0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;
  logic         tready;
  logic [191:0] reg_map_data;
  logic [5:0]   reg_update;
  logic         frame_done;
  logic         frame_err;
  logic [15:0]  err_count;

  int total = 0;
  int bad = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  axi_cmd_reg_map_writer dut (
    .axi_tclk      (clk),
    .axi_treset    (rst),
    .enable        (enable),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .reg_map_data  (reg_map_data),
    .reg_update    (reg_update),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .err_count     (err_count)
  );

  // Model: collect accepted words of the current frame, judge the whole frame at tlast.
  logic [31:0] m_live [6];
  logic [31:0] cur [$];
  logic [5:0]  m_upd;
  logic        m_done, m_err;
  int          m_errcnt;

  always @(posedge clk) begin
    m_upd  = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      for (int i = 0; i < 6; i++) m_live[i] = '0;
      cur.delete();
      m_errcnt = 0;
    end else if (tvalid && tready) begin
      cur.push_back(tdata);
      if (tlast) begin
        bit fbad;
        fbad = (cur.size() % 2) != 0;
        for (int k = 0; k + 1 < cur.size(); k += 2)
          if (cur[k][7:0] >= 6) fbad = 1'b1;
        if (fbad) begin
          m_err = 1'b1;
          if (m_errcnt < 65535) m_errcnt++;
        end else begin
          for (int k = 0; k + 1 < cur.size(); k += 2) begin
            m_live[cur[k][7:0]] = cur[k+1];
            m_upd[cur[k][7:0]]  = 1'b1;
          end
          m_done = 1'b1;
        end
        cur.delete();
      end
    end
  end

  function automatic logic [191:0] model_map();
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = m_live[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("map", reg_map_data, model_map());
      check("upd", 192'(reg_update), 192'(m_upd));
      check("done", 192'(frame_done), 192'(m_done));
      check("err", 192'(frame_err), 192'(m_err));
      check("errcnt", 192'(err_count), 192'(m_errcnt));
      check("ready", 192'(tready), 192'((cur.size() > 0) ? 1'b1 : enable));
    end
  end

  function automatic logic [31:0] reg_at(input int i);
    return reg_map_data[i*32 +: 32];
  endfunction

  task automatic send(input logic [31:0] d, input logic l);
    bit acc;
    int n;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    acc    = 1'b0;
    n      = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no beat want beat for word %h", d);
    end
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    model_on = 1'b1;
    check("rst_map", reg_map_data, '0);
    check("rst_ready", 192'(tready), 192'(1'b0));
    check("rst_errcnt", 192'(err_count), 192'(0));
    rst = 1'b0;
    enable = 1'b1;
    idle(1);

    // clean frame
    send(32'h0, 1'b0); send(32'h11, 1'b0); send(32'h5, 1'b0); send(32'h55, 1'b1);
    tvalid = 1'b0;
    check("t1_reg0", 192'(reg_at(0)), 192'(32'h11));
    check("t1_reg5", 192'(reg_at(5)), 192'(32'h55));
    check("t1_upd", 192'(reg_update), 192'(6'b100001));
    check("t1_done", 192'(frame_done), 192'(1'b1));
    idle(2);

    // out-of-range address
    send(32'h2, 1'b0); send(32'hAA, 1'b0); send(32'h9, 1'b0); send(32'hBB, 1'b1);
    tvalid = 1'b0;
    check("t2_err", 192'(frame_err), 192'(1'b1));
    check("t2_errcnt", 192'(err_count), 192'(1));
    check("t2_upd", 192'(reg_update), 192'(0));
    check("t2_reg2", 192'(reg_at(2)), 192'(0));
    idle(2);

    // odd word count then a clean frame
    send(32'h3, 1'b1);
    tvalid = 1'b0;
    check("t3_err", 192'(frame_err), 192'(1'b1));
    check("t3_errcnt", 192'(err_count), 192'(2));
    idle(1);
    send(32'h1, 1'b0); send(32'h7, 1'b1);
    tvalid = 1'b0;
    check("t3_reg1", 192'(reg_at(1)), 192'(32'h7));
    idle(2);

    // enable gating only blocks frame start
    enable = 1'b0;
    idle(3);
    check("t4_ready_idle", 192'(tready), 192'(1'b0));
    enable = 1'b1;
    send(32'h4, 1'b0);
    enable = 1'b0;
    send(32'h44, 1'b0); send(32'h0, 1'b0); send(32'h99, 1'b1);
    tvalid = 1'b0;
    check("t4_reg4", 192'(reg_at(4)), 192'(32'h44));
    check("t4_reg0", 192'(reg_at(0)), 192'(32'h99));
    check("t4_done", 192'(frame_done), 192'(1'b1));
    idle(1);
    check("t4_ready_after", 192'(tready), 192'(1'b0));
    enable = 1'b1;
    idle(1);

    // same address twice, then a back-to-back frame
    send(32'h3, 1'b0); send(32'h1, 1'b0); send(32'h3, 1'b0); send(32'h2, 1'b1);
    check("t5_reg3", 192'(reg_at(3)), 192'(32'h2));
    check("t5_upd", 192'(reg_update), 192'(6'b001000));
    send(32'h2, 1'b0); send(32'h22, 1'b1);
    tvalid = 1'b0;
    check("t5_reg2", 192'(reg_at(2)), 192'(32'h22));
    check("t5_upd2", 192'(reg_update), 192'(6'b000100));
    idle(2);

    // reset in the middle of a frame
    send(32'h1, 1'b0);
    tvalid = 1'b0;
    rst = 1'b1;
    idle(2);
    check("t6_map", reg_map_data, '0);
    check("t6_errcnt", 192'(err_count), 192'(0));
    rst = 1'b0;
    idle(1);
    send(32'h0, 1'b0); send(32'h5A, 1'b1);
    tvalid = 1'b0;
    check("t6_reg0", 192'(reg_at(0)), 192'(32'h5A));
    check("t6_upd", 192'(reg_update), 192'(6'b000001));
    idle(1);

    // error counter saturation
    for (int i = 0; i < 65535; i++) send(32'h0, 1'b1);
    tvalid = 1'b0;
    check("t7_errcnt_max", 192'(err_count), 192'(16'hFFFF));
    idle(1);
    send(32'h7, 1'b1);
    tvalid = 1'b0;
    check("t7_errcnt_sat", 192'(err_count), 192'(16'hFFFF));
    check("t7_err", 192'(frame_err), 192'(1'b1));
    idle(2);

    model_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
